// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB slave memory.
//   apb_state_e   - transfer FSM state (IDLE, ACCESS, DONE)
//   CNT_W         - width of the wait-state counter
//   DEF_*         - default parameter values for apb_slave_mem
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

  localparam int CNT_W = 4;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 12;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_STATES = 0;

endpackage

// File: rtl/apb_slave_mem_array.sv
// apb_slave_mem_array: DEPTH x DATA_WIDTH word storage.
// Ports:
//   clk      - write clock
//   we       - write enable (one word per cycle)
//   wr_idx   - word index for the write
//   wr_data  - write data
//   wr_strb  - per-byte write enables
//   rd_idx   - word index for the combinational read port
//   rd_data  - read data (0 for an index beyond DEPTH)
// Contents are never reset.
module apb_slave_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Guard against non-power-of-two depths where the index field can exceed DEPTH-1.
  assign rd_data = ({1'b0, rd_idx} < DEPTH_LIM) ? mem[rd_idx] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave backed by a word-addressed memory with
// configurable wait states and out-of-range error response.
// Ports:
//   PCLK     - clock, all state changes on the rising edge
//   PRESET   - asynchronous active-high reset
//   PSEL     - slave select
//   PENABLE  - access phase
//   PWRITE   - 1 = write, 0 = read
//   PADDR    - byte address
//   PWDATA   - write data
//   PSTRB    - byte-lane write enables (ignored on reads)
//   PRDATA   - registered read data
//   PREADY   - transfer completion
//   PSLVERR  - error response, only ever high together with PREADY
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(BYTES);
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0]    WAIT_CNT  = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  apb_state_e state_q;
  logic [CNT_W-1:0] cnt_q;

  // Transfer context captured at setup; later bus changes are ignored.
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      strb_q;
  logic                  wr_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  in_range;
  logic                  setup;
  logic                  accept;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // Low address bits select a byte within the word and are dropped.
  assign word_addr = PADDR >> OFF_W;
  assign in_range  = ({1'b0, word_addr} < DEPTH_LIM);
  assign setup     = PSEL && !PENABLE;
  assign accept    = setup && (state_q != ACCESS);

  // The write lands on the edge that closes the PREADY=1 cycle.
  assign mem_we = (state_q == ACCESS) && PSEL && PENABLE && PREADY && wr_q && !err_q;

  apb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (PCLK),
    .we      (mem_we),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_strb (strb_q),
    .rd_idx  (word_addr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge PCLK) begin
    if (accept) begin
      idx_q   <= word_addr[IDX_W-1:0];
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
      wr_q    <= PWRITE;
      err_q   <= !in_range;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state_q)
        // DONE accepts a setup exactly like IDLE so transfers can run back to back.
        IDLE, DONE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          if (setup) begin
            state_q <= ACCESS;
            cnt_q   <= WAIT_CNT;
            PREADY  <= ZERO_WAIT;
            PSLVERR <= ZERO_WAIT && !in_range;
            // Read data is captured at setup; memory cannot change before completion.
            if (!in_range) begin
              PRDATA <= '0;
            end else if (!PWRITE) begin
              PRDATA <= rd_data;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        ACCESS: begin
          if (!PSEL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (PENABLE) begin
            if (PREADY) begin
              state_q <= DONE;
              PREADY  <= 1'b0;
              PSLVERR <= 1'b0;
            end else begin
              // PREADY is raised for the cycle in which the counter reads zero.
              cnt_q   <= cnt_q - CNT_W'(1);
              PREADY  <= (cnt_q == CNT_W'(1));
              PSLVERR <= (cnt_q == CNT_W'(1)) && err_q;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [3:0]    pstrb = '0;
  int            dsel = 0;

  logic          psel0, psel3;
  logic [DW-1:0] prdata0, prdata3;
  logic          pready0, pready3, pslverr0, pslverr3;

  assign psel0 = psel && (dsel == 0);
  assign psel3 = psel && (dsel == 3);

  always #5 clk = ~clk;

  apb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic sample(output logic rdy, output logic err, output logic [31:0] rd);
    if (dsel == 0) begin
      rdy = pready0; err = pslverr0; rd = prdata0;
    end else begin
      rdy = pready3; err = pslverr3; rd = prdata3;
    end
  endtask

  // One APB transfer on the selected DUT. The bus is left asserted after
  // completion so a following call issues its setup in the DONE cycle.
  // Address/data/control are scrambled during the access phase.
  task automatic xfer(input bit sync, input bit wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic err, output int waits);
    logic rdy, e;
    logic [31:0] r;
    bit done;
    done = 1'b0;
    if (sync) begin
      @(posedge clk); #1;
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1; paddr = ~a; pwdata = ~wd; pstrb = ~st; pwrite = ~wr;
    waits = 0; rd = '0; err = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      sample(rdy, e, r);
      if (rdy) begin
        done = 1'b1; rd = r; err = e;
      end else begin
        check("pslverr_low_while_busy", {31'b0, e}, 32'd0);
        waits++;
        @(posedge clk); #1;
      end
    end
    check("xfer_completed", {31'b0, done}, 32'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          exp_waits;
    logic        exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          waits;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 12'h020, 32'h00000000, 4'h5, 0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 12'h020, 32'h0,        4'hF, 0, 1'b0, 1'b1, 32'hFF00FF00};
    vecs[5]  = '{1'b1, 12'h000, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 12'h400, 32'h12345678, 4'hF, 0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 12'h400, 32'h0,        4'h0, 0, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, 0, 1'b0, 1'b1, 32'hA5A5A5A5};
    vecs[9]  = '{1'b0, 12'h013, 32'h0,        4'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 12'h3FC, 32'h0BADF00D, 4'hF, 0, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 12'h3FC, 32'h0,        4'h0, 0, 1'b0, 1'b1, 32'h0BADF00D};

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_async_pready0",  {31'b0, pready0},  32'd0);
    check("rst_async_pslverr0", {31'b0, pslverr0}, 32'd0);
    check("rst_async_prdata0",  prdata0,           32'd0);
    check("rst_async_pready3",  {31'b0, pready3},  32'd0);
    check("rst_async_prdata3",  prdata3,           32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven transfers on the zero-wait instance; the first setup is
    // issued in the very first cycle after reset release.
    dsel = 0;
    for (int i = 0; i < 12; i++) begin
      xfer(i != 0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, waits);
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
      check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
    end
    idle();

    // PENABLE without a preceding setup must be ignored
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h0; pstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("no_setup_pready", {31'b0, pready0}, 32'd0);
    end
    idle();
    xfer(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, waits);
    check("no_setup_nowrite", rd, 32'hA5A5A5A5);
    idle();

    // Wait-state instance
    dsel = 3;
    xfer(1'b1, 1'b1, 12'h000, 32'h11223344, 4'hF, rd, err, waits);
    check("ws3_write_waits", 32'(waits), 32'd3);
    check("ws3_write_err", {31'b0, err}, 32'd0);
    xfer(1'b1, 1'b0, 12'h000, 32'h0, 4'h0, rd, err, waits);
    check("ws3_read_waits", 32'(waits), 32'd3);
    check("ws3_read_data", rd, 32'h11223344);

    // Abort: PSEL falls during the wait states
    xfer(1'b1, 1'b1, 12'h030, 32'hCAFEF00D, 4'hF, rd, err, waits);
    idle();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_wait1_pready", {31'b0, pready3}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_wait2_pready", {31'b0, pready3}, 32'd0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_pready",  {31'b0, pready3},  32'd0);
      check("abort_pslverr", {31'b0, pslverr3}, 32'd0);
    end
    xfer(1'b1, 1'b0, 12'h030, 32'h0, 4'h0, rd, err, waits);
    check("abort_readback", rd, 32'hCAFEF00D);

    // Reset during the access wait of a write
    xfer(1'b1, 1'b1, 12'h040, 32'h5555AAAA, 4'hF, rd, err, waits);
    xfer(1'b1, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, waits);
    check("pre_rst_read", rd, 32'h5555AAAA);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h040; pwdata = 32'h12121212; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_pready",  {31'b0, pready3},  32'd0);
    check("midrst_pslverr", {31'b0, pslverr3}, 32'd0);
    check("midrst_prdata",  prdata3,           32'd0);
    check("midrst_prdata0", prdata0,           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(1'b0, 1'b0, 12'h040, 32'h0, 4'h0, rd, err, waits);
    check("post_rst_waits", 32'(waits), 32'd3);
    check("post_rst_word", rd, 32'h5555AAAA);
    idle();

    // Memory contents survive reset
    dsel = 0;
    xfer(1'b1, 1'b0, 12'h010, 32'h0, 4'h0, rd, err, waits);
    check("mem_kept_across_rst", rd, 32'hDEADBEEF);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
